// File: rtl/ex_fp_sequencer_pkg.sv
// Shared definitions for the execute-stage FP sequencer: FSM state encodings,
// FP operation codes and the legal-op check.
package ex_fp_sequencer_pkg;

  localparam int FP_OP_W = 4;
  localparam int RD_W    = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  typedef enum logic [FP_OP_W-1:0] {
    FP_ADD = 4'd0,
    FP_SUB = 4'd1,
    FP_MUL = 4'd2,
    FP_DIV = 4'd3,
    FP_ABS = 4'd4,
    FP_CMP = 4'd5
  } fp_op_e;

  // An op code is legal when it lies in 0..num_ops-1.
  function automatic logic fp_op_legal(input logic [FP_OP_W-1:0] op, input int unsigned num_ops);
    return (32'(op) < num_ops);
  endfunction

endpackage

// File: rtl/ex_fp_sequencer_if.sv
// Start/done handshake between the FP sequencer (master) and the external
// multi-cycle FP core (slave).
interface ex_fp_sequencer_if
  import ex_fp_sequencer_pkg::*;
#(
  parameter int DATA_W = 32
);
  logic               fp_start;
  logic [FP_OP_W-1:0] fp_op;
  logic [DATA_W-1:0]  fp_a;
  logic [DATA_W-1:0]  fp_b;
  logic               fp_done;
  logic [DATA_W-1:0]  fp_result;

  modport master (
    output fp_start, fp_op, fp_a, fp_b,
    input  fp_done, fp_result
  );

  modport slave (
    input  fp_start, fp_op, fp_a, fp_b,
    output fp_done, fp_result
  );
endinterface

// File: rtl/ex_fp_sequencer_fp_watchdog_counter.sv
// Wait-cycle counter for the FP sequencer watchdog: cleared on issue,
// incremented while waiting, saturating at all-ones, with a terminal-count
// flag raised when the count reaches MAX_LAT-1. Used with FP_TIMEOUT_EN.
module fp_watchdog_counter #(
  parameter int LAT_W   = 5,
  parameter int MAX_LAT = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic term_o
);
  localparam logic [LAT_W-1:0] CNT_SAT  = {LAT_W{1'b1}};
  localparam logic [LAT_W-1:0] CNT_TERM = LAT_W'(MAX_LAT - 1);

  logic [LAT_W-1:0] cnt_q;
  logic [LAT_W-1:0] cnt_d;

  // Next count: clear wins over increment; increment stops at saturation.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {LAT_W{1'b0}};
    end else if (inc_i && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + {{(LAT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {LAT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == CNT_TERM);
endmodule

// File: rtl/ex_fp_sequencer.sv
// Execute-stage FP sequencer. Accepts FP instructions from the decode/execute
// register, issues them to the FP core, stalls the front end until completion
// and presents result/rd/regwrite towards EX/MEM with a one-cycle valid pulse.
// Optional watchdog timeout: define FP_TIMEOUT_EN.
module ex_fp_sequencer
  import ex_fp_sequencer_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int LAT_W      = 5,
  parameter int MAX_LAT    = 20,
  parameter int NUM_FP_OPS = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               de_valid,
  input  logic               fp_instr_de,
  input  logic [FP_OP_W-1:0] fp_aluop_de,
  input  logic [DATA_W-1:0]  rs_data_de,
  input  logic [DATA_W-1:0]  rt_data_de,
  input  logic [RD_W-1:0]    rd_de,
  input  logic               regwrite_de,
  ex_fp_sequencer_if.master  fp_if,
  output logic               stall,
  output logic               ex_fp_valid,
  output logic [DATA_W-1:0]  ex_fp_result,
  output logic [RD_W-1:0]    ex_fp_rd,
  output logic               ex_fp_regwrite,
  output logic               fp_error
);
  seq_state_e         state_q, state_d;
  logic [FP_OP_W-1:0] op_q;
  logic [DATA_W-1:0]  a_q, b_q, res_q;
  logic [RD_W-1:0]    rd_q, ex_rd_q;
  logic               rw_q, ex_rw_q, err_q;

  logic               accept_s, legal_s, timeout_s, cnt_clr_s, cnt_inc_s;
  logic               load_s, err_d;
  logic [DATA_W-1:0]  res_d;
  logic [RD_W-1:0]    rd_d;
  logic               rw_d;

  assign accept_s  = (state_q == ST_IDLE) && de_valid && fp_instr_de;
  assign legal_s   = fp_op_legal(fp_aluop_de, NUM_FP_OPS);
  assign cnt_clr_s = (state_q == ST_ISSUE);
  assign cnt_inc_s = (state_q == ST_WAIT);

`ifdef FP_TIMEOUT_EN
  logic wd_term_s;
  fp_watchdog_counter #(.LAT_W(LAT_W), .MAX_LAT(MAX_LAT)) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (cnt_clr_s),
    .inc_i  (cnt_inc_s),
    .term_o (wd_term_s)
  );
  assign timeout_s = wd_term_s;
`else
  logic [LAT_W-1:0] cnt_q, cnt_d;

  // Wait-cycle count without a bound: clear on issue, saturating increment in WAIT.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_s) begin
      cnt_d = {LAT_W{1'b0}};
    end else if (cnt_inc_s && (cnt_q != {LAT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(LAT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Wait-cycle count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {LAT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_s = 1'b0;
`endif

  // Next state plus the completion record loaded on entry to DONE.
  always_comb begin
    state_d = state_q;
    load_s  = 1'b0;
    err_d   = 1'b0;
    res_d   = {DATA_W{1'b0}};
    rd_d    = rd_q;
    rw_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && legal_s) begin
          state_d = ST_ISSUE;
        end else if (accept_s) begin
          // Illegal op never reaches the core; rd comes straight from decode.
          state_d = ST_DONE;
          load_s  = 1'b1;
          err_d   = 1'b1;
          rd_d    = rd_de;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (fp_if.fp_done) begin
          state_d = ST_DONE;
          load_s  = 1'b1;
          res_d   = fp_if.fp_result;
          rw_d    = rw_q;
        end else if (timeout_s) begin
          state_d = ST_DONE;
          load_s  = 1'b1;
          err_d   = 1'b1;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction fields captured on accept, stable until the op completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q <= {FP_OP_W{1'b0}};
      a_q  <= {DATA_W{1'b0}};
      b_q  <= {DATA_W{1'b0}};
      rd_q <= {RD_W{1'b0}};
      rw_q <= 1'b0;
    end else if (accept_s) begin
      op_q <= fp_aluop_de;
      a_q  <= rs_data_de;
      b_q  <= rt_data_de;
      rd_q <= rd_de;
      rw_q <= regwrite_de;
    end
  end

  // Completion record towards EX/MEM, held until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= {DATA_W{1'b0}};
      ex_rd_q <= {RD_W{1'b0}};
      ex_rw_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (load_s) begin
      res_q   <= res_d;
      ex_rd_q <= rd_d;
      ex_rw_q <= rw_d;
      err_q   <= err_d;
    end
  end

  assign fp_if.fp_start = (state_q == ST_ISSUE);
  assign fp_if.fp_op    = op_q;
  assign fp_if.fp_a     = a_q;
  assign fp_if.fp_b     = b_q;

  assign stall          = accept_s || (state_q == ST_ISSUE) || (state_q == ST_WAIT);
  assign ex_fp_valid    = (state_q == ST_DONE);
  assign ex_fp_result   = res_q;
  assign ex_fp_rd       = ex_rd_q;
  assign ex_fp_regwrite = ex_rw_q;
  assign fp_error       = err_q;
endmodule

// File: tb/tb_ex_fp_sequencer.sv
// Self-checking bench for ex_fp_sequencer: directed scenarios plus random
// instructions, each checked against a per-instruction timeline model.
module tb_ex_fp_sequencer;
  import ex_fp_sequencer_pkg::*;

  localparam int DATA_W  = 32;
  localparam int MAX_LAT = 20;
  localparam int NUM_OPS = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              de_valid = 1'b0, fp_instr_de = 1'b0, regwrite_de = 1'b0;
  logic [3:0]        fp_aluop_de = 4'd0;
  logic [DATA_W-1:0] rs_data_de = '0, rt_data_de = '0;
  logic [4:0]        rd_de = 5'd0;
  logic              stall, ex_fp_valid, ex_fp_regwrite, fp_error;
  logic [DATA_W-1:0] ex_fp_result;
  logic [4:0]        ex_fp_rd;

  ex_fp_sequencer_if #(.DATA_W(DATA_W)) fp_if ();

  ex_fp_sequencer #(.DATA_W(DATA_W), .LAT_W(5), .MAX_LAT(MAX_LAT), .NUM_FP_OPS(NUM_OPS)) dut (
    .clk(clk), .rst_n(rst_n), .de_valid(de_valid), .fp_instr_de(fp_instr_de),
    .fp_aluop_de(fp_aluop_de), .rs_data_de(rs_data_de), .rt_data_de(rt_data_de),
    .rd_de(rd_de), .regwrite_de(regwrite_de), .fp_if(fp_if), .stall(stall),
    .ex_fp_valid(ex_fp_valid), .ex_fp_result(ex_fp_result), .ex_fp_rd(ex_fp_rd),
    .ex_fp_regwrite(ex_fp_regwrite), .fp_error(fp_error)
  );

  always #5 clk = ~clk;

  int cyc_g = 0;
  always @(posedge clk) cyc_g <= cyc_g + 1;

  int checks = 0;
  int errors = 0;

  // Values the EX/MEM outputs must keep between completions.
  logic [DATA_W-1:0] prev_res = '0;
  logic [4:0]        prev_rd = 5'd0;
  logic              prev_rw = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    de_valid = 1'b0; fp_instr_de = 1'b0; fp_aluop_de = 4'd0; rs_data_de = '0;
    rt_data_de = '0; rd_de = 5'd0; regwrite_de = 1'b0;
    fp_if.fp_done = 1'b0; fp_if.fp_result = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_start"}, 64'(fp_if.fp_start), 64'd0);
    chk({tag, "_op"}, 64'(fp_if.fp_op), 64'd0);
    chk({tag, "_a"}, 64'(fp_if.fp_a), 64'd0);
    chk({tag, "_b"}, 64'(fp_if.fp_b), 64'd0);
    chk({tag, "_stall"}, 64'(stall), 64'd0);
    chk({tag, "_valid"}, 64'(ex_fp_valid), 64'd0);
    chk({tag, "_result"}, 64'(ex_fp_result), 64'd0);
    chk({tag, "_rd"}, 64'(ex_fp_rd), 64'd0);
    chk({tag, "_rw"}, 64'(ex_fp_regwrite), 64'd0);
    chk({tag, "_err"}, 64'(fp_error), 64'd0);
  endtask

  // Presents one instruction at posedge+1 and plays the FP core.
  // d = WAIT cycle (1-based) on which fp_done is raised; 0 = never.
  // Timeline from the spec: accept c=0, fp_start c=1, fp_done c=1+d, valid c=2+d.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd, input logic rw,
                           input int d, input logic spur, output int start_g, output int valid_g);
    logic legal, tmo, exp_err, seen;
    logic [31:0] res, exp_res;
    int wait_n, exp_vc, n_stall, n_start, n_valid, start_c, valid_c, base;
    legal = (int'(op) < NUM_OPS);
    res = $urandom;
`ifdef FP_TIMEOUT_EN
    tmo = legal && (d == 0 || d > MAX_LAT);
`else
    tmo = 1'b0;
`endif
    wait_n  = tmo ? MAX_LAT : d;
    exp_vc  = legal ? 2 + wait_n : 1;
    exp_err = !legal || tmo;
    exp_res = exp_err ? 32'd0 : res;
    n_stall = 0; n_start = 0; n_valid = 0; start_c = -1; valid_c = -1;
    seen = 1'b0; base = cyc_g;
    for (int c = 0; c < 80 && !seen; c++) begin
      if (c == 0) begin
        de_valid = 1'b1; fp_instr_de = 1'b1; fp_aluop_de = op;
        rs_data_de = a; rt_data_de = b; rd_de = rd; regwrite_de = rw;
      end else begin
        // Bubble with random noise: must not disturb the latched instruction.
        de_valid = 1'b0; fp_instr_de = 1'($urandom); fp_aluop_de = 4'($urandom);
        rs_data_de = $urandom; rt_data_de = $urandom; rd_de = 5'($urandom);
        regwrite_de = 1'($urandom);
      end
      fp_if.fp_done   = (legal && d != 0 && c == 1 + d) || (spur && c == 1);
      fp_if.fp_result = (legal && d != 0 && c == 1 + d) ? res : $urandom;
      @(negedge clk);
      if (c == 0) begin
        chk({tag, "_held_valid"}, 64'(ex_fp_valid), 64'd0);
        chk({tag, "_held_result"}, 64'(ex_fp_result), 64'(prev_res));
        chk({tag, "_held_rd"}, 64'(ex_fp_rd), 64'(prev_rd));
        chk({tag, "_held_rw"}, 64'(ex_fp_regwrite), 64'(prev_rw));
      end
      if (stall) n_stall++;
      if (fp_if.fp_start) begin
        n_start++; start_c = c;
        chk({tag, "_fp_op"}, 64'(fp_if.fp_op), 64'(op));
        chk({tag, "_fp_a"}, 64'(fp_if.fp_a), 64'(a));
        chk({tag, "_fp_b"}, 64'(fp_if.fp_b), 64'(b));
      end
      if (ex_fp_valid) begin
        n_valid++; valid_c = c; seen = 1'b1;
        chk({tag, "_result"}, 64'(ex_fp_result), 64'(exp_res));
        chk({tag, "_rd"}, 64'(ex_fp_rd), 64'(rd));
        chk({tag, "_rw"}, 64'(ex_fp_regwrite), 64'(rw && !exp_err));
        chk({tag, "_err"}, 64'(fp_error), 64'(exp_err));
      end
      @(posedge clk); #1;
    end
    fp_if.fp_done = 1'b0; de_valid = 1'b0;
    chk({tag, "_valid_seen"}, 64'(n_valid), 64'd1);
    chk({tag, "_valid_cycle"}, 64'(valid_c), 64'(exp_vc));
    chk({tag, "_start_count"}, 64'(n_start), 64'(legal ? 1 : 0));
    if (legal) chk({tag, "_start_cycle"}, 64'(start_c), 64'd1);
    else       chk({tag, "_start_cycle"}, 64'(start_c), 64'hFFFF_FFFF_FFFF_FFFF);
    chk({tag, "_stall_cycles"}, 64'(n_stall), 64'(exp_vc));
    start_g = base + start_c;
    valid_g = base + valid_c;
    prev_res = exp_res; prev_rd = rd; prev_rw = rw && !exp_err;
  endtask

  initial begin
    int sg, vg, sg2, vg2, d;
    logic [3:0] op;
    idle_inputs();
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic ADD with fp_done three cycles after fp_start.
    run_instr("add", FP_ADD, 32'h3F80_0000, 32'h4000_0000, 5'd7, 1'b1, 3, 1'b0, sg, vg);

    // Illegal op code 9.
    run_instr("illegal", 4'd9, 32'h1234_5678, 32'h9ABC_DEF0, 5'd12, 1'b1, 1, 1'b0, sg, vg);

    // Bubble carrying an FP instruction must be ignored.
    for (int i = 0; i < 4; i++) begin
      de_valid = 1'b0; fp_instr_de = 1'b1; fp_aluop_de = FP_MUL;
      rs_data_de = $urandom; rt_data_de = $urandom; rd_de = 5'd3; regwrite_de = 1'b1;
      @(negedge clk);
      chk("bubble_stall", 64'(stall), 64'd0);
      chk("bubble_start", 64'(fp_if.fp_start), 64'd0);
      chk("bubble_valid", 64'(ex_fp_valid), 64'd0);
      @(posedge clk); #1;
    end

    // Two back-to-back MULs with distinct operands; spurious fp_done in ISSUE.
    run_instr("mul1", FP_MUL, 32'h4040_0000, 32'h4080_0000, 5'd1, 1'b1, 2, 1'b1, sg, vg);
    run_instr("mul2", FP_MUL, 32'hC0A0_0000, 32'h40C0_0000, 5'd2, 1'b0, 1, 1'b0, sg2, vg2);
    chk("b2b_start_gap", 64'(sg2 - vg), 64'd2);

`ifdef FP_TIMEOUT_EN
    run_instr("timeout", FP_DIV, 32'h1, 32'h0, 5'd9, 1'b1, 0, 1'b0, sg, vg);
    run_instr("term_done", FP_DIV, 32'h5, 32'h6, 5'd10, 1'b1, MAX_LAT, 1'b0, sg, vg);
`else
    run_instr("long_wait", FP_DIV, 32'h5, 32'h6, 5'd10, 1'b1, MAX_LAT + 5, 1'b0, sg, vg);
`endif

    // Random instructions.
    for (int i = 0; i < 16; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(6, 15)) : 4'($urandom_range(0, 5));
`ifdef FP_TIMEOUT_EN
      d = $urandom_range(0, 24);
`else
      d = $urandom_range(1, 10);
`endif
      run_instr("rand", op, $urandom, $urandom, 5'($urandom), 1'($urandom), d,
                1'($urandom), sg, vg);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    // Reset while in WAIT: everything clears, a late fp_done is ignored.
    de_valid = 1'b1; fp_instr_de = 1'b1; fp_aluop_de = FP_SUB;
    rs_data_de = 32'hAAAA_5555; rt_data_de = 32'h5555_AAAA; rd_de = 5'd31; regwrite_de = 1'b1;
    @(posedge clk); #1;
    de_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    fp_if.fp_done = 1'b1; fp_if.fp_result = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("postreset_valid", 64'(ex_fp_valid), 64'd0);
      chk("postreset_stall", 64'(stall), 64'd0);
      chk("postreset_start", 64'(fp_if.fp_start), 64'd0);
      chk("postreset_result", 64'(ex_fp_result), 64'd0);
      @(posedge clk); #1;
      fp_if.fp_done = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
